// File: rtl/regwb_pkg.sv
// Shared widths, the queued write-back entry type and the hard-wired zero register.
package regwb_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wb_queue.sv
// Pending-write FIFO: two pushes per cycle (push_a lands before push_b) and one pop.
// The raw entry array and read pointer are exported so the forwarding search can walk it.
module wb_queue
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_a,
  input  wb_entry_t                  entry_a,
  input  logic                       push_b,
  input  wb_entry_t                  entry_b,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH)-1:0]   rptr,
  output wb_entry_t [DEPTH-1:0]      entries
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wptr;
  logic [CW-1:0] n_push;

  assign n_push = CW'(push_a) + CW'(push_b);
  assign head   = entries[rptr];

  // Storage is not reset: a slot is only observable once count covers it.
  always_ff @(posedge clk) begin
    if (push_a) entries[wptr] <= entry_a;
    if (push_b) entries[push_a ? wptr + PW'(1) : wptr] <= entry_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(n_push);
      rptr  <= rptr + PW'(pop);
      count <= count + n_push - CW'(pop);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side initiator for the register file: queues ALU/load results and retires one per cycle.
// Optional forwarding lookup is built only when REGWB_FWD_EN is defined.
module regfile_writeback
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] in,
  output logic              write,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  output logic              fwd_a_hit,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_b_data,
  output logic              pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]         count;
  logic [PW-1:0]         rptr;
  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t             head;
  wb_entry_t             mem_entry;
  wb_entry_t             alu_entry;
  logic                  push_mem;
  logic                  push_alu;
  logic                  pop;

  // Handshake: a result transfers on a rising edge where valid & ready are both high.
  // Readies depend only on the registered count; alu keeps one slot of headroom so a
  // simultaneous mem+alu acceptance always fits.
  assign mem_ready = (count <= CW'(DEPTH - 1));
  assign alu_ready = (count <= CW'(DEPTH - 2));

  assign mem_entry = '{rd: mem_rd, data: mem_data};
  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign push_mem  = mem_valid & mem_ready & (mem_rd != ZERO_REG);
  assign push_alu  = alu_valid & alu_ready & (alu_rd != ZERO_REG);
  assign pop       = (count != '0);

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_a  (push_mem),
    .entry_a (mem_entry),
    .push_b  (push_alu),
    .entry_b (alu_entry),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .rptr    (rptr),
    .entries (entries)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      write <= 1'b0;
      rd    <= '0;
      in    <= '0;
    end else if (pop) begin
      write <= 1'b1;
      rd    <= head.rd;
      in    <= head.data;
    end else begin
      write <= 1'b0;
    end
  end

  assign pending = (count != '0) | write;

`ifdef REGWB_FWD_EN
  // Walk oldest to newest so later matches override; the output register is older than any queued entry.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [REG_W-1:0] q);
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [PW-1:0]     idx;
    hit  = 1'b0;
    data = '0;
    if (write && rd == q) begin
      hit  = 1'b1;
      data = in;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < count && entries[idx].rd == q) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
    if (q == ZERO_REG) begin
      hit  = 1'b0;
      data = '0;
    end
    return {hit, data};
  endfunction

  always_comb begin
    {fwd_a_hit, fwd_a_data} = fwd_lookup(rs);
    {fwd_b_hit, fwd_b_data} = fwd_lookup(rt);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs, rt, rptr, entries};

  assign fwd_a_hit  = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_hit  = 1'b0;
  assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: behavioural pending-write queue as scoreboard,
// every cycle checks write/rd/in/pending/readies/forwarding against it.
module tb_regfile_writeback;
  import regwb_pkg::*;

  localparam int DEPTH = 4;
`ifdef REGWB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [REG_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic [REG_W-1:0]  rd;
  logic [DATA_W-1:0] in;
  logic              write;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic              fwd_a_hit;
  logic [DATA_W-1:0] fwd_a_data;
  logic              fwd_b_hit;
  logic [DATA_W-1:0] fwd_b_data;
  logic              pending;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .rd         (rd),
    .in         (in),
    .write      (write),
    .rs         (rs),
    .rt         (rt),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_b_data (fwd_b_data),
    .pending    (pending)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: entries {rd, data} still waiting in the DUT queue, oldest first.
  logic [REG_W+DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic              last_w;
  logic [REG_W-1:0]  last_rd;
  logic [DATA_W-1:0] last_in;
  bit                acc_alu;
  bit                acc_mem;
  bit                saw_alu_stall;
  bit                primed;
  int                na;
  int                nm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W:0] fwd_model(input logic [REG_W-1:0] q);
    logic              hit;
    logic [DATA_W-1:0] d;
    hit = 1'b0;
    d   = '0;
    if (FWD_EN && q != 5'd0) begin
      if (last_w && last_rd == q) begin
        hit = 1'b1;
        d   = last_in;
      end
      foreach (exp_q[i]) begin
        if (exp_q[i][REG_W+DATA_W-1:DATA_W] == q) begin
          hit = 1'b1;
          d   = exp_q[i][DATA_W-1:0];
        end
      end
    end
    return {hit, d};
  endfunction

  // One clock: check readies, predict the edge, then check every output #1 after it.
  task automatic tick();
    logic [REG_W+DATA_W-1:0] e;
    logic [DATA_W:0]         fa;
    logic [DATA_W:0]         fb;
    bit                      exp_w;
    int                      sz;
    sz = exp_q.size();
    if (primed) begin
      check("mem_ready", 32'(mem_ready), 32'(sz <= DEPTH - 1));
      check("alu_ready", 32'(alu_ready), 32'(sz <= DEPTH - 2));
    end
    acc_mem = mem_valid && (sz <= DEPTH - 1);
    acc_alu = alu_valid && (sz <= DEPTH - 2);
    if (!rst && alu_valid && !acc_alu) saw_alu_stall = 1'b1;
    exp_w = 1'b0;
    if (rst) begin
      exp_q.delete();
      last_rd = '0;
      last_in = '0;
      acc_mem = 1'b0;
      acc_alu = 1'b0;
    end else begin
      if (sz != 0) begin
        e       = exp_q.pop_front();
        exp_w   = 1'b1;
        last_rd = e[REG_W+DATA_W-1:DATA_W];
        last_in = e[DATA_W-1:0];
      end
      if (acc_mem && mem_rd != 5'd0) exp_q.push_back({mem_rd, mem_data});
      if (acc_alu && alu_rd != 5'd0) exp_q.push_back({alu_rd, alu_data});
    end
    last_w = exp_w;
    @(posedge clk);
    #1;
    check("write", 32'(write), 32'(exp_w));
    check("rd", 32'(rd), 32'(last_rd));
    check("in", in, last_in);
    check("pending", 32'(pending), 32'((exp_q.size() != 0) || exp_w));
    fa = fwd_model(rs);
    fb = fwd_model(rt);
    check("fwd_a_hit", 32'(fwd_a_hit), 32'(fa[DATA_W]));
    check("fwd_b_hit", 32'(fwd_b_hit), 32'(fb[DATA_W]));
    if (fa[DATA_W] || !FWD_EN) check("fwd_a_data", fwd_a_data, fa[DATA_W-1:0]);
    if (fb[DATA_W] || !FWD_EN) check("fwd_b_data", fwd_b_data, fb[DATA_W-1:0]);
  endtask

  initial begin
    rst = 1'b1; primed = 1'b0; saw_alu_stall = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    rs = 5'd7; rt = 5'd0;
    last_w = 1'b0; last_rd = '0; last_in = '0;

    // Reset held two edges while the ALU offers a result
    tick();
    primed = 1'b1;
    tick();
    rst = 1'b0; alu_valid = 1'b0;
    repeat (3) tick();

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'd22; rs = 5'd2;
    tick();
    alu_valid = 1'b0;
    repeat (3) tick();

    // Load to $0 is consumed but never written
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'd11; rs = 5'd0;
    tick();
    mem_valid = 1'b0;
    repeat (2) tick();

    // Simultaneous mem + alu: mem retires first
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'd33;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'd44;
    rs = 5'd3; rt = 5'd5;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    repeat (4) tick();

    // Backpressure: dual streams fill the queue until alu_ready drops
    na = 1; nm = 1;
    for (int cyc = 0; cyc < 60 && (na <= 6 || nm <= 6); cyc++) begin
      alu_valid = (na <= 6); alu_rd = 5'(na);      alu_data = 32'(100 + na);
      mem_valid = (nm <= 6); mem_rd = 5'(10 + nm); mem_data = 32'(200 + nm);
      rs = 5'($urandom_range(0, 16));
      rt = 5'($urandom_range(0, 16));
      tick();
      if (acc_alu) na++;
      if (acc_mem) nm++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("bp_all_sent", 32'(na > 6 && nm > 6), 32'd1);
    check("bp_alu_stall_seen", 32'(saw_alu_stall), 32'd1);
    repeat (8) tick();

    // Forwarding: youngest of two writes to r2 wins, query r0 never hits
    rs = 5'd2; rt = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'd22;
    tick();
    alu_data = 32'd99;
    tick();
    alu_valid = 1'b0;
    repeat (3) tick();

    // Reset with three entries queued
    mem_valid = 1'b1; mem_rd = 5'd8;  mem_data = 32'h88;
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h99;
    tick();
    mem_rd = 5'd10; mem_data = 32'haa;
    alu_rd = 5'd11; alu_data = 32'hbb;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    rs = 5'd11; rt = 5'd9; rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
